// File: rtl/burn_integrator_if.sv
// Parameter and result bundle between the stage manager (master) and the
// burn integrator (slave).
interface burn_integrator_if #(
  parameter int N = 64
);
  logic [3:0]   stage;
  logic [N-1:0] specific_impulse;
  logic [N-1:0] initial_weight;
  logic [N-1:0] weight_propellant;
  logic [N-1:0] burntime;
  logic         ignition_end;
  logic         burning;
  logic [N-1:0] mass_flow;
  logic [N-1:0] thrust;
  logic [N-1:0] current_weight;
  logic [N-1:0] elapsed;

  modport master (
    output stage, specific_impulse, initial_weight, weight_propellant, burntime,
    input  ignition_end, burning, mass_flow, thrust, current_weight, elapsed
  );

  modport slave (
    input  stage, specific_impulse, initial_weight, weight_propellant, burntime,
    output ignition_end, burning, mass_flow, thrust, current_weight, elapsed
  );
endinterface

// File: rtl/burn_integrator.sv
// Engine-burn pacing: captures stage parameters, divides out mass flow, forms
// thrust, then integrates vehicle mass once per simulated second.
module burn_integrator #(
  parameter int PERIOD     = 10,
  parameter int N          = 64,
  parameter int SCALE      = 1000,
  parameter int GRAVITY    = 9_799 * SCALE / 1000,
  parameter int LOAD_DELAY = 2
) (
  input  logic             clk,
  input  logic             resetb,
  burn_integrator_if.slave bus
);
  localparam int SW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int LW = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
  localparam int BW = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, MUL, BURN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    stage_q, stage_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [N-1:0]  isp_q, isp_d;
  logic [N-1:0]  iw_q, iw_d;
  logic [N-1:0]  wp_q, wp_d;
  logic [N-1:0]  bt_q, bt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  mass_flow_q, mass_flow_d;
  logic [N-1:0]  thrust_q, thrust_d;
  logic [N-1:0]  weight_q, weight_d;
  logic [N-1:0]  elapsed_q, elapsed_d;
  logic          burning_q, burning_d;
  logic          ign_q, ign_d;
  logic          new_stage;
  logic [N:0]    trial;

  always_comb begin
    state_d     = state_q;
    stage_d     = bus.stage;
    load_cnt_d  = load_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    isp_d       = isp_q;
    iw_d        = iw_q;
    wp_d        = wp_q;
    bt_d        = bt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    mass_flow_d = mass_flow_q;
    thrust_d    = thrust_q;
    weight_d    = weight_q;
    elapsed_d   = elapsed_q;
    new_stage   = (bus.stage != stage_q) && (bus.stage >= 4'd1) && (bus.stage <= 4'd4);
    trial       = {rem_q, quo_q[N-1]};

    case (state_q)
      IDLE: ;
      LOAD: begin
        if (load_cnt_q == LW'(LOAD_DELAY - 1)) begin
          isp_d       = bus.specific_impulse;
          iw_d        = bus.initial_weight;
          wp_d        = bus.weight_propellant;
          bt_d        = bus.burntime;
          quo_d       = bus.weight_propellant;
          rem_d       = '0;
          bit_cnt_d   = '0;
          mass_flow_d = '0;
          thrust_d    = '0;
          weight_d    = bus.initial_weight;
          elapsed_d   = '0;
          state_d     = (bus.burntime == '0) ? DONE : DIV;
        end else begin
          load_cnt_d = load_cnt_q + LW'(1);
        end
      end
      // Restoring division: the dividend register shifts out its MSB into the
      // partial remainder and collects quotient bits at its LSB.
      DIV: begin
        if (trial >= {1'b0, bt_q}) begin
          rem_d = N'(trial - {1'b0, bt_q});
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = trial[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(N - 1)) state_d = MUL;
      end
      MUL: begin
        mass_flow_d = quo_q;
        thrust_d    = isp_q * quo_q * N'(GRAVITY);
        sec_cnt_d   = '0;
        state_d     = BURN;
      end
      BURN: begin
        if (sec_cnt_q == SW'(PERIOD - 1)) begin
          sec_cnt_d = '0;
          elapsed_d = elapsed_q + N'(1);
          // Final second lands exactly on the burnout mass, absorbing the remainder.
          if (elapsed_q + N'(1) == bt_q) begin
            weight_d = iw_q - wp_q;
            state_d  = DONE;
          end else begin
            weight_d = weight_q - mass_flow_q;
          end
        end else begin
          sec_cnt_d = sec_cnt_q + SW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (new_stage) begin
      state_d    = LOAD;
      load_cnt_d = '0;
    end
    burning_d = (state_d == BURN);
    ign_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      load_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      sec_cnt_q   <= '0;
      isp_q       <= '0;
      iw_q        <= '0;
      wp_q        <= '0;
      bt_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      mass_flow_q <= '0;
      thrust_q    <= '0;
      weight_q    <= '0;
      elapsed_q   <= '0;
      burning_q   <= 1'b0;
      ign_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      load_cnt_q  <= load_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      isp_q       <= isp_d;
      iw_q        <= iw_d;
      wp_q        <= wp_d;
      bt_q        <= bt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      mass_flow_q <= mass_flow_d;
      thrust_q    <= thrust_d;
      weight_q    <= weight_d;
      elapsed_q   <= elapsed_d;
      burning_q   <= burning_d;
      ign_q       <= ign_d;
    end
  end

  assign bus.ignition_end   = ign_q;
  assign bus.burning        = burning_q;
  assign bus.mass_flow      = mass_flow_q;
  assign bus.thrust         = thrust_q;
  assign bus.current_weight = weight_q;
  assign bus.elapsed        = elapsed_q;
endmodule

// File: tb/tb_burn_integrator.sv
// Directed bench for burn_integrator: a queue of expected end-of-burn results is
// filled as each stage is driven and drained on every ignition_end pulse.
module tb_burn_integrator;
  localparam int N          = 64;
  localparam int PERIOD     = 10;
  localparam int LOAD_DELAY = 2;
  localparam int GRAVITY    = 9799;

  logic clk    = 1'b0;
  logic resetb = 1'b1;

  burn_integrator_if #(.N(N)) bus ();

  burn_integrator #(
    .PERIOD(PERIOD), .N(N), .LOAD_DELAY(LOAD_DELAY)
  ) dut (
    .clk(clk), .resetb(resetb), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mass_flow;
    logic [N-1:0] thrust;
    logic [N-1:0] weight;
    logic [N-1:0] elapsed;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;
  int ign_count   = 0;
  int burn_count  = 0;

  logic [N-1:0] tbl_isp [4] = '{64'd263, 64'd300, 64'd350, 64'd400};
  logic [N-1:0] tbl_iw  [4] = '{64'd500000, 64'd200000, 64'd99999, 64'd49999};
  logic [N-1:0] tbl_wp  [4] = '{64'd300000, 64'd100001, 64'd50000, 64'd49998};
  logic [N-1:0] tbl_bt  [4] = '{64'd3, 64'd2, 64'd4, 64'd1};

  always @(negedge clk) begin
    if (bus.ignition_end === 1'b1) ign_count++;
    if (bus.burning === 1'b1) burn_count++;
  end

  task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                             input logic [N-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives a stage on the next falling edge and queues the expected burnout state.
  task automatic applyStimulus(input logic [3:0] s, input logic [N-1:0] isp,
                               input logic [N-1:0] iw, input logic [N-1:0] wp,
                               input logic [N-1:0] bt);
    exp_t e;
    @(negedge clk);
    bus.stage             = s;
    bus.specific_impulse  = isp;
    bus.initial_weight    = iw;
    bus.weight_propellant = wp;
    bus.burntime          = bt;
    if (s >= 4'd1 && s <= 4'd4) begin
      e.mass_flow = (bt == '0) ? '0 : wp / bt;
      e.thrust    = isp * e.mass_flow * N'(GRAVITY);
      e.weight    = (bt == '0) ? iw : iw - wp;
      e.elapsed   = bt;
      sb.push_back(e);
    end
  endtask

  task automatic waitForIgnition(input int budget, output int cycles);
    cycles = 0;
    while (bus.ignition_end !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.ignition_end !== 1'b1) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL ignition_timeout: observed no pulse, expected one within %0d clocks", budget);
    end
  endtask

  task automatic waitForBurn(input int budget, output int cycles);
    cycles = 0;
    while (bus.burning !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.burning !== 1'b1) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL burn_timeout: observed no burning, expected it within %0d clocks", budget);
    end
  endtask

  task automatic checkCompletion(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s.scoreboard: observed ignition_end, expected no pending stage", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, ".mass_flow"}, bus.mass_flow, e.mass_flow);
      checkOutput({tag, ".thrust"}, bus.thrust, e.thrust);
      checkOutput({tag, ".current_weight"}, bus.current_weight, e.weight);
      checkOutput({tag, ".elapsed"}, bus.elapsed, e.elapsed);
      checkOutput({tag, ".burning"}, N'(bus.burning), '0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ignition_end"}, N'(bus.ignition_end), '0);
    checkOutput({tag, ".burning"}, N'(bus.burning), '0);
    checkOutput({tag, ".mass_flow"}, bus.mass_flow, '0);
    checkOutput({tag, ".thrust"}, bus.thrust, '0);
    checkOutput({tag, ".current_weight"}, bus.current_weight, '0);
    checkOutput({tag, ".elapsed"}, bus.elapsed, '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int ign0;
    int burn0;

    bus.stage             = '0;
    bus.specific_impulse  = '0;
    bus.initial_weight    = '0;
    bus.weight_propellant = '0;
    bus.burntime          = '0;

    // Reset and a long idle stretch at stage 0.
    #2 resetb = 1'b0;
    #1 checkAllZero("reset");
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    ign0  = ign_count;
    burn0 = burn_count;
    repeat (100) @(negedge clk);
    checkAllZero("idle");
    checkOutput("idle.ign_pulses", N'(ign_count - ign0), '0);
    checkOutput("idle.burn_clocks", N'(burn_count - burn0), '0);

    // Stage 1 with the reference first-stage numbers.
    ign0 = ign_count;
    applyStimulus(4'd1, 64'd263, 64'd2875403, 64'd2077000, 64'd168);
    waitForBurn(200, cyc);
    checkOutput("s1.burn_latency", N'(cyc), N'(LOAD_DELAY + 1 + N + 1));
    checkOutput("s1.mass_flow", bus.mass_flow, 64'd12363);
    checkOutput("s1.thrust", bus.thrust, 64'd31861144731);
    checkOutput("s1.entry_weight", bus.current_weight, 64'd2875403);
    checkOutput("s1.entry_elapsed", bus.elapsed, 64'd0);
    repeat (PERIOD) @(negedge clk);
    checkOutput("s1.sec1_weight", bus.current_weight, 64'd2863040);
    checkOutput("s1.sec1_elapsed", bus.elapsed, 64'd1);
    waitForIgnition(1800, cyc);
    checkOutput("s1.burn_clocks", N'(cyc + PERIOD), 64'd1680);
    checkCompletion("s1");
    checkOutput("s1.final_weight", bus.current_weight, 64'd798403);
    @(negedge clk);
    checkOutput("s1.pulse_width", N'(bus.ignition_end), '0);
    checkOutput("s1.ign_pulses", N'(ign_count - ign0), 64'd1);
    checkOutput("s1.hold_weight", bus.current_weight, 64'd798403);

    // Stage 3: remainder absorbed on the final second.
    applyStimulus(4'd3, 64'd300, 64'd100000, 64'd39136, 64'd165);
    waitForIgnition(2000, cyc);
    checkCompletion("s3");
    checkOutput("s3.mass_flow", bus.mass_flow, 64'd237);
    checkOutput("s3.final_weight", bus.current_weight, 64'd60864);
    checkOutput("s3.elapsed", bus.elapsed, 64'd165);

    // Stage 2 with zero burntime: no division, no burn.
    burn0 = burn_count;
    applyStimulus(4'd2, 64'd250, 64'd77777, 64'd5000, 64'd0);
    waitForIgnition(20, cyc);
    checkOutput("bt0.latency", N'(cyc), N'(LOAD_DELAY + 1));
    checkCompletion("bt0");
    checkOutput("bt0.weight", bus.current_weight, 64'd77777);
    checkOutput("bt0.burn_clocks", N'(burn_count - burn0), '0);

    // Closed loop: each ignition_end advances the stage, ending at stage 5.
    applyStimulus(4'd0, '0, '0, '0, '0);
    repeat (5) @(negedge clk);
    ign0 = ign_count;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'(i + 1), tbl_isp[i], tbl_iw[i], tbl_wp[i], tbl_bt[i]);
      waitForIgnition(200, cyc);
      checkCompletion($sformatf("loop%0d", i + 1));
    end
    burn0 = burn_count;
    applyStimulus(4'd5, 64'd100, 64'd1000, 64'd500, 64'd5);
    repeat (200) @(negedge clk);
    checkOutput("loop.ign_pulses", N'(ign_count - ign0), 64'd4);
    checkOutput("loop.stage5_burn", N'(burn_count - burn0), '0);
    checkOutput("loop.stage5_pending", N'(sb.size()), '0);

    // Asynchronous reset in the middle of second 50 of a stage-1 burn.
    ign0 = ign_count;
    applyStimulus(4'd1, 64'd263, 64'd2875403, 64'd2077000, 64'd168);
    waitForBurn(200, cyc);
    repeat (50 * PERIOD + 5) @(negedge clk);
    checkOutput("abort.elapsed_before", bus.elapsed, 64'd50);
    #2 resetb = 1'b0;
    #1 checkAllZero("abort");
    sb.delete();
    bus.stage = '0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort.ign_pulses", N'(ign_count - ign0), '0);
    applyStimulus(4'd2, 64'd100, 64'd5000, 64'd3000, 64'd2);
    waitForIgnition(200, cyc);
    checkOutput("post_rst.latency", N'(cyc), N'(LOAD_DELAY + 1 + N + 1 + 2 * PERIOD));
    checkCompletion("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
